// File: rtl/alu_op_sequencer.sv
// Control-side sequencer for the 32-bit ALU: decodes MIPS words into ALU
// OP/select, drives operands, runs MULTU as shift-add passes, returns results.
module alu_op_sequencer #(
  parameter int MUL_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_OP,
  output logic [2:0]  alu_select,
  input  logic [31:0] alu_res,
  input  logic        alu_cout,
  input  logic        alu_V,
  input  logic        alu_Z,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [2:0]  res_flags,
  output logic        branch_taken,
  output logic        ovf_trap,
  output logic        illegal
);

  localparam int CNT_W = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_ADDK  = 6'h1C;

  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [2:0]  sel;
    logic        trap_en;
    logic        br_eq;
    logic        br_ne;
    logic        illegal;
    logic        is_mul;
  } dec_t;

  state_t state, state_nx;
  dec_t   dec, ctl;

  logic [31:0]      op_a;     // EXEC operand A, or the shifting multiplicand in MUL
  logic [31:0]      op_b;     // EXEC operand B, or the shifting multiplier in MUL
  logic [31:0]      acc;
  logic [31:0]      acc_nx;
  logic [CNT_W-1:0] cnt;
  logic             mul_last;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign imm           = instr[15:0];
  assign unused_fields = ^instr[25:16];

  // Decode of the offered word; only latched on accept.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    dec     = '0;
    dec.a   = rs_data;
    dec.b   = rt_data;
    dec.op  = ALU_ADD;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADD:   begin dec.op = ALU_ADD; dec.trap_en = 1'b1; end
          FN_ADDU:  dec.op = ALU_ADD;
          FN_SUB:   begin dec.op = ALU_SUB; dec.trap_en = 1'b1; end
          FN_SUBU:  dec.op = ALU_SUB;
          FN_AND:   dec.op = ALU_AND;
          FN_OR:    dec.op = ALU_OR;
          FN_SLT:   dec.op = ALU_SLT;
          FN_MULTU: dec.is_mul = 1'b1;
          default:  dec.illegal = 1'b1;
        endcase
      end
      OPC_ADDI: begin
        dec.b       = {{16{imm[15]}}, imm};
        dec.op      = ALU_ADD;
        dec.trap_en = 1'b1;
      end
      OPC_SLTI: begin
        dec.b  = {{16{imm[15]}}, imm};
        dec.op = ALU_SLT;
      end
      OPC_ANDI: begin
        dec.b  = {16'h0000, imm};
        dec.op = ALU_AND;
      end
      OPC_ORI: begin
        dec.b  = {16'h0000, imm};
        dec.op = ALU_OR;
      end
      OPC_BEQ: begin
        dec.op    = ALU_SUB;
        dec.br_eq = 1'b1;
      end
      OPC_BNE: begin
        dec.op    = ALU_SUB;
        dec.br_ne = 1'b1;
      end
      OPC_ADDK: begin
        // The ALU's own A+k path; select values 0 and 7 are not increments.
        if (imm[2:0] == 3'd0 || imm[2:0] == 3'd7) begin
          dec.illegal = 1'b1;
        end else begin
          dec.sel = imm[2:0];
          dec.b   = 32'h0;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.a   = 32'h0;
      dec.b   = 32'h0;
      dec.op  = ALU_ADD;
      dec.sel = 3'd0;
    end
  end

  assign mul_last = (cnt == CNT_W'(MUL_ITERS - 1));
  assign acc_nx   = op_b[0] ? alu_res : acc;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (instr_valid) state_nx = dec.is_mul ? S_MUL : S_EXEC;
      S_EXEC:  state_nx = S_RESP;
      S_MUL:   if (mul_last) state_nx = S_RESP;
      S_RESP:  if (res_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == S_IDLE);
    res_valid   = (state == S_RESP);
    alu_A       = 32'h0;
    alu_B       = 32'h0;
    alu_OP      = ALU_ADD;
    alu_select  = 3'd0;
    case (state)
      S_EXEC: begin
        alu_A      = op_a;
        alu_B      = op_b;
        alu_OP     = ctl.op;
        alu_select = ctl.sel;
      end
      S_MUL: begin
        alu_A = acc;
        alu_B = op_a;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ctl          <= '0;
      op_a         <= 32'h0;
      op_b         <= 32'h0;
      acc          <= 32'h0;
      cnt          <= '0;
      res_data     <= 32'h0;
      res_flags    <= 3'b000;
      branch_taken <= 1'b0;
      ovf_trap     <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ctl  <= dec;
            op_a <= dec.a;
            op_b <= dec.b;
            acc  <= 32'h0;
            cnt  <= '0;
          end
        end
        S_EXEC: begin
          res_data     <= ctl.illegal ? 32'h0 : alu_res;
          res_flags    <= ctl.illegal ? 3'b000 : {alu_cout, alu_V, alu_Z};
          branch_taken <= (ctl.br_eq & alu_Z) | (ctl.br_ne & ~alu_Z);
          ovf_trap     <= ctl.trap_en & alu_V;
          illegal      <= ctl.illegal;
        end
        S_MUL: begin
          acc  <= acc_nx;
          op_a <= op_a << 1;
          op_b <= op_b >> 1;
          cnt  <= cnt + 1'b1;
          if (mul_last) begin
            res_data     <= acc_nx;
            res_flags    <= {2'b00, (acc_nx == 32'h0)};
            branch_taken <= 1'b0;
            ovf_trap     <= 1'b0;
            illegal      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer: a behavioural ALU answers the DUT's
// operand/OP requests; a MIPS-semantics reference predicts every result.
module tb_alu_op_sequencer;

  localparam int MUL_ITERS = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [2:0]  alu_OP;
  logic [2:0]  alu_select;
  logic [31:0] alu_res;
  logic        alu_cout;
  logic        alu_V;
  logic        alu_Z;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_flags;
  logic        branch_taken;
  logic        ovf_trap;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  alu_op_sequencer #(.MUL_ITERS(MUL_ITERS)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data),
    .alu_A(alu_A), .alu_B(alu_B), .alu_OP(alu_OP), .alu_select(alu_select),
    .alu_res(alu_res), .alu_cout(alu_cout), .alu_V(alu_V), .alu_Z(alu_Z),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .branch_taken(branch_taken), .ovf_trap(ovf_trap),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // {carry, signed overflow, sum} of a+b or a-b (two's complement).
  function automatic logic [33:0] adder(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [31:0] bb;
    logic [32:0] s;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {32'h0, sub};
    return {s[32], (a[31] == bb[31]) && (s[31] != a[31]), s[31:0]};
  endfunction

  // Behavioural 32-bit ALU: carry/overflow always come from the adder.
  always_comb begin
    logic [33:0] af;
    if (alu_select != 3'd0) begin
      af      = adder(alu_A, {29'h0, alu_select}, 1'b0);
      alu_res = af[31:0];
    end else begin
      af = adder(alu_A, alu_B, alu_OP[2]);
      case (alu_OP)
        3'b000:  alu_res = alu_A & alu_B;
        3'b001:  alu_res = alu_A | alu_B;
        3'b010:  alu_res = af[31:0];
        3'b110:  alu_res = af[31:0];
        3'b111:  alu_res = ($signed(alu_A) < $signed(alu_B)) ? 32'd1 : 32'd0;
        default: alu_res = 32'hDEADBEEF;
      endcase
    end
    alu_cout = af[33];
    alu_V    = af[32];
    alu_Z    = (alu_res == 32'h0);
  end

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  flags;
    logic        br;
    logic        trap;
    logic        ill;
    logic        mul;
    logic [2:0]  sel;
  } exp_t;

  // Expected outcome from instruction semantics; flags are what the ALU
  // reports for the operands that instruction should present to it.
  function automatic exp_t ref_model(input logic [31:0] iw, input logic [31:0] rs, input logic [31:0] rt);
    exp_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] im;
    logic [31:0] se;
    logic [31:0] ze;
    logic [33:0] af;
    logic [63:0] prod;
    op = iw[31:26];
    fn = iw[5:0];
    im = iw[15:0];
    se = {{16{im[15]}}, im};
    ze = {16'h0, im};
    e  = '0;
    af = '0;
    e.ill = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: begin e.data = rs + rt; af = adder(rs, rt, 1'b0); e.trap = af[32]; end
          6'h21: begin e.data = rs + rt; af = adder(rs, rt, 1'b0); end
          6'h22: begin e.data = rs - rt; af = adder(rs, rt, 1'b1); e.trap = af[32]; end
          6'h23: begin e.data = rs - rt; af = adder(rs, rt, 1'b1); end
          6'h24: begin e.data = rs & rt; af = adder(rs, rt, 1'b0); end
          6'h25: begin e.data = rs | rt; af = adder(rs, rt, 1'b0); end
          6'h2A: begin e.data = ($signed(rs) < $signed(rt)) ? 1 : 0; af = adder(rs, rt, 1'b1); end
          6'h19: begin prod = {32'h0, rs} * {32'h0, rt}; e.data = prod[31:0]; e.mul = 1'b1; end
          default: e.ill = 1'b1;
        endcase
      end
      6'h08: begin e.data = rs + se; af = adder(rs, se, 1'b0); e.trap = af[32]; end
      6'h0A: begin e.data = ($signed(rs) < $signed(se)) ? 1 : 0; af = adder(rs, se, 1'b1); end
      6'h0C: begin e.data = rs & ze; af = adder(rs, ze, 1'b0); end
      6'h0D: begin e.data = rs | ze; af = adder(rs, ze, 1'b0); end
      6'h04: begin e.data = rs - rt; af = adder(rs, rt, 1'b1); e.br = (rs == rt); end
      6'h05: begin e.data = rs - rt; af = adder(rs, rt, 1'b1); e.br = (rs != rt); end
      6'h1C: begin
        if (im[2:0] == 3'd0 || im[2:0] == 3'd7) e.ill = 1'b1;
        else begin
          e.sel  = im[2:0];
          e.data = rs + {29'h0, im[2:0]};
          af     = adder(rs, {29'h0, im[2:0]}, 1'b0);
        end
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) e.data = 32'h0;
    if (e.ill || e.mul) e.flags = {2'b00, e.data == 32'h0};
    else                e.flags = {af[33], af[32], e.data == 32'h0};
    if (e.ill) e.flags = 3'b000;
    return e;
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] im);
    return {op, 5'd1, 5'd2, im};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("wait_ready", {31'h0, instr_ready}, 32'd1);
  endtask

  // Offer one instruction, measure latency, check the response, then hold
  // res_ready low for 'hold' cycles before accepting it.
  task automatic run_op(input string name, input logic [31:0] iw, input logic [31:0] rs,
                        input logic [31:0] rt, input int hold);
    exp_t e;
    int   lat;
    e = ref_model(iw, rs, rt);
    wait_ready();
    instr_valid = 1'b1;
    instr       = iw;
    rs_data     = rs;
    rt_data     = rt;
    res_ready   = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = $urandom;
    rs_data     = $urandom;
    rt_data     = $urandom;
    if (!e.mul) check({name, "_sel"}, 32'(alu_select), 32'(e.sel));
    while (!res_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, "_latency"}, lat, e.mul ? MUL_ITERS + 1 : 2);
    check({name, "_data"}, res_data, e.data);
    check({name, "_flags"}, 32'(res_flags), 32'(e.flags));
    check({name, "_branch"}, 32'(branch_taken), 32'(e.br));
    check({name, "_trap"}, 32'(ovf_trap), 32'(e.trap));
    check({name, "_illegal"}, 32'(illegal), 32'(e.ill));
    check({name, "_busy"}, 32'(instr_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(res_valid), 32'd1);
      check({name, "_hold_data"}, res_data, e.data);
      check({name, "_hold_busy"}, 32'(instr_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check({name, "_done_valid"}, 32'(res_valid), 32'd0);
    check({name, "_done_ready"}, 32'(instr_ready), 32'd1);
  endtask

  task automatic reset_during_mul();
    int seen = 0;
    wait_ready();
    instr_valid = 1'b1;
    instr       = rtype(6'h19);
    rs_data     = 32'h1234_5678;
    rt_data     = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mulrst_ready", 32'(instr_ready), 32'd1);
    check("mulrst_valid", 32'(res_valid), 32'd0);
    check("mulrst_data", res_data, 32'h0);
    check("mulrst_aluA", alu_A, 32'h0);
    res_ready = 1'b1;
    for (int i = 0; i < MUL_ITERS + 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (res_valid) seen++;
    end
    res_ready = 1'b0;
    check("mulrst_no_result", seen, 0);
  endtask

  initial begin
    logic [31:0] iw;
    logic [31:0] rs;
    logic [31:0] rt;
    int          k;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'h0;
    rs_data     = 32'h0;
    rt_data     = 32'h0;
    res_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_data", res_data, 32'h0);
    check("rst_flags", {26'h0, res_flags, branch_taken, ovf_trap, illegal}, 32'h0);
    check("rst_alu", {alu_A | alu_B, 32'h0} == 64'h0 ? {26'h0, alu_OP, alu_select} : 32'hFFFF_FFFF,
          {26'h0, 3'b010, 3'b000});

    run_op("add_ovf", rtype(6'h20), 32'h7FFF_FFFF, 32'h1, 0);
    run_op("beq", itype(6'h04, 16'h0010), 32'h1234, 32'h1234, 1);
    run_op("bne", itype(6'h05, 16'h0010), 32'h1234, 32'h1234, 0);
    run_op("addk5", itype(6'h1C, 16'h0005), 32'hFFFF_FFFE, 32'h0, 0);
    run_op("addk7", itype(6'h1C, 16'h0007), 32'hFFFF_FFFE, 32'h0, 0);
    run_op("multu", rtype(6'h19), 32'h0001_0003, 32'h0000_0005, 4);
    run_op("slti", itype(6'h0A, 16'h0001), 32'hFFFF_FFFF, 32'h0, 0);
    run_op("andi", itype(6'h0C, 16'h8001), 32'hFFFF_FFFF, 32'h0, 0);
    run_op("sub_ovf", rtype(6'h22), 32'h8000_0000, 32'h1, 0);
    run_op("illegal_op", itype(6'h3F, 16'h1234), 32'h5, 32'h6, 0);

    reset_during_mul();
    run_op("add_after_rst", rtype(6'h20), 32'd2, 32'd3, 0);

    for (int n = 0; n < 48; n++) begin
      k = $urandom_range(0, 15);
      case (k)
        0:  iw = rtype(6'h20);
        1:  iw = rtype(6'h21);
        2:  iw = rtype(6'h22);
        3:  iw = rtype(6'h23);
        4:  iw = rtype(6'h24);
        5:  iw = rtype(6'h25);
        6:  iw = rtype(6'h2A);
        7:  iw = rtype(6'h19);
        8:  iw = itype(6'h08, 16'($urandom));
        9:  iw = itype(6'h0A, 16'($urandom));
        10: iw = itype(6'h0C, 16'($urandom));
        11: iw = itype(6'h0D, 16'($urandom));
        12: iw = itype(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, 16'($urandom));
        13: iw = itype(6'h1C, 16'($urandom));
        14: iw = rtype(6'($urandom_range(0, 15)));
        default: iw = itype(6'($urandom_range(48, 63)), 16'($urandom));
      endcase
      case ($urandom_range(0, 5))
        0:       rs = 32'h7FFF_FFFF;
        1:       rs = 32'h8000_0000;
        2:       rs = 32'h0;
        default: rs = $urandom;
      endcase
      rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      run_op("rand", iw, rs, rt, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control-side counterpart of the 32-bit ALU: decodes MIPS instruction words into the ALU's OP[2:0]/select[2:0] encoding and drives the A/B operands.
- Samples the ALU's result and flags (resAlu32, c_out, V, Z) and returns a registered result via a valid/ready handshake.
- Sequences a multi-cycle MULTU as 32 shift-add passes through the same ALU adder.
- Sits between register-read and writeback in the processor datapath.

Parameters:
- MUL_ITERS, 32, number of shift-add passes for MULTU (fixed 32 in this design; parameterised for bench speed-up only).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer idle and can accept
- instr  in  32  MIPS instruction word
- rs_data  in  32  rs operand
- rt_data  in  32  rt operand
- alu_A  out  32  ALU operand A
- alu_B  out  32  ALU operand B
- alu_OP  out  3  ALU OP: AND=000, OR=001, ADD=010, SUB=110, SLT=111
- alu_select  out  3  ALU result mux: 0 = core result, 1..6 = A+k; 7 is never driven
- alu_res  in  32  ALU resAlu32
- alu_cout  in  1  ALU c_out
- alu_V  in  1  ALU overflow
- alu_Z  in  1  ALU zero
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  32  result word
- res_flags  out  3  {c_out, V, Z} sampled with the result
- branch_taken  out  1  BEQ/BNE decision, valid with res_valid
- ovf_trap  out  1  signed overflow on ADD/ADDI/SUB, valid with res_valid
- illegal  out  1  undecodable instruction, valid with res_valid

Behaviour:
Reset values:
- State IDLE; instr_ready=1.
- res_valid, res_data, res_flags, branch_taken, ovf_trap, illegal all 0.
- alu_A=alu_B=0, alu_OP=010, alu_select=0.
- Reset mid-operation aborts any instruction, including MULTU in progress. No res_valid is produced for the aborted instruction.

States:
- IDLE: instr_ready=1. On instr_valid&&!reset, latch instr, rs_data, rt_data. Go to MUL if decoded MULTU, else EXEC.
- EXEC (1 cycle): drive alu_A/alu_B/alu_OP/alu_select from latched values. At the clock edge, capture alu_res, flags, branch/trap/illegal into output registers. Go to RESP.
- MUL: counter i = 0..MUL_ITERS-1.
  - alu_A=acc, alu_B=mcand, OP=ADD, select=0.
  - At each edge: if mplier[0], acc<=alu_res. Then mcand<=mcand<<1, mplier<=mplier>>1.
  - acc starts at 0; mcand=rs; mplier=rt.
  - After the last pass go to RESP. res_data = low 32 bits of rs*rt; res_flags = {0,0,(res_data==0)}.
- RESP: res_valid=1. Outputs held stable until res_ready; on res_valid&&res_ready return to IDLE. instr_ready=0 in RESP (no overlap).
- Latency, valid accept to res_valid: 2 cycles for single-pass ops; MUL_ITERS+1 cycles for MULTU.

Decode (A=rs unless stated):
- R-type (op 0x00), funct:
  - 0x20 add → ADD, ovf_trap=V
  - 0x21 addu → ADD, no trap
  - 0x22 sub → SUB, ovf_trap=V
  - 0x23 subu → SUB, no trap
  - 0x24 and → AND
  - 0x25 or → OR
  - 0x2A slt → SLT
  - 0x19 multu → MUL state
- I-type, B=extended imm:
  - 0x08 addi → sign-extended imm, ADD, trap on V
  - 0x0A slti → sign-extended imm, SLT
  - 0x0C andi → zero-extended imm, AND
  - 0x0D ori → zero-extended imm, OR
- Branches (B=rt, SUB):
  - 0x04 beq → branch_taken=Z
  - 0x05 bne → branch_taken=!Z
- 0x1C addk:
  - alu_select=imm[2:0], valid range 1..6; result = rs+k.
  - imm[2:0] of 0 or 7 is illegal.
- Any other op/funct is illegal:
  - illegal=1, res_data=0, flags 0.
  - Still passes through EXEC→RESP; ALU inputs 0.
- Flags:
  - res_flags are always the ALU values sampled in EXEC.
  - ovf_trap and branch_taken are 0 for ops not listed above.

Test Plan:
- add rs=0x7FFFFFFF, rt=1 → res_data 0x80000000, ovf_trap=1, res_flags V=1, res_valid 2 cycles after accept.
- beq rs=rt=0x1234 → res_data 0, Z=1, branch_taken=1. bne with the same operands → branch_taken=0.
- addk with imm=5, rs=0xFFFFFFFE → alu_select=5, res_data 0x00000003, c_out=1. imm=7 → illegal=1, res_data=0.
- multu rs=0x00010003, rt=0x00000005 → res_data 0x0005000F, res_valid exactly 33 cycles after accept. With res_ready held low for 4 cycles, outputs stay stable and instr_ready stays 0.
- slti rs=0xFFFFFFFF, imm=0x0001 → res_data 1. andi rs=0xFFFFFFFF, imm=0x8001 → res_data 0x00008001 (zero-extended).
- reset asserted at MUL pass 10 → next cycle: IDLE, instr_ready=1, res_valid=0. A new add 2+3 then returns 5.
